gin_ifmap_scheduler: RTL and testbench
======================================

# gin_ifmap_scheduler

Sequencer in front of the GIN ifmap multicast network. After `start`, it performs three steps in order:
- Shifts the row-tag chain (XBUS_NUMS beats) into the GIN scan ports.
- Shifts the PE-ID chain (XBUS_NUMS*PE_NUMS beats) into the GIN scan ports.
- Streams a column-major ifmap tile into the GIN, generating `row_tag`/`col_tag` per beat and honouring the GIN `ready` handshake.

It replaces the hand-sequenced scan/stream stimulus with synthesizable control sitting between the global buffer read port and the GIN.

## Interface
Parameters:
- XBUS_NUMS, 12, number of X-buses (row-tag chain length)
- PE_NUMS, 14, PEs per X-bus
- ID_LEN, 5, PE ID / col_tag width
- ROW_LEN, 4, row_tag width
- VALUE_LEN, 8, ifmap value width
- IFMAP_ROWS, 60, ifmap rows per column
- IFMAP_COLS, 224, ifmap columns per tile
- ROWS_PER_TAG, 30, ifmap rows sharing one row_tag; col_tag wraps at this value
- GAP_CYCLES, 3, idle cycles between scan completion and the first stream beat

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  begin one full sequence; sampled only in IDLE
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last ifmap transfer
- cfg_valid  in  1  scan word available
- cfg_data  in  8  scan word; low ROW_LEN bits in the row phase, low ID_LEN bits in the ID phase
- cfg_ready  out  1  scan word accepted this cycle when high together with cfg_valid
- src_valid  in  1  ifmap word available
- src_data  in  VALUE_LEN  ifmap word, column-major order (c outer, r inner)
- src_ready  out  1  ifmap word accepted when high together with src_valid
- gin_set_row  out  1  GIN set_row
- gin_row_scan_in  out  ROW_LEN  GIN row_scan_in
- gin_set_id  out  1  GIN set_id
- gin_id_scan_in  out  ID_LEN  GIN id_scan_in
- gin_enable  out  1  GIN enable (output register holds a valid beat)
- gin_row_tag  out  ROW_LEN  GIN row_tag
- gin_col_tag  out  ID_LEN  GIN col_tag
- gin_value  out  VALUE_LEN  GIN value
- gin_ready  in  1  GIN ready; a transfer occurs on a cycle with gin_enable && gin_ready

## Operation
- FSM states: IDLE, SCAN_ROW, SCAN_ID, GAP, STREAM, DONE.
- IDLE → SCAN_ROW on `start`.
- SCAN_ROW:
  - `cfg_ready`=1.
  - Each cfg handshake registers `gin_set_row`=1 and `gin_row_scan_in`=cfg_data[ROW_LEN-1:0] for exactly one cycle.
  - A cycle without a handshake drives `gin_set_row`=0, so the chain does not shift.
  - → SCAN_ID after beat XBUS_NUMS-1.
- SCAN_ID: same rules on the ID ports, XBUS_NUMS*PE_NUMS beats; → GAP.
- GAP: counts GAP_CYCLES cycles with all strobes low; → STREAM.
- STREAM:
  - Single-entry output register; `src_ready` = !gin_enable || gin_ready.
  - Each accepted src word loads `gin_value` and the current tags, and sets `gin_enable`.
  - `gin_enable` clears after a transfer unless a new word is accepted in the same cycle.
  - Tags, value and enable stay stable while gin_enable && !gin_ready.
- Tag counters advance on src acceptance:
  - col_tag increments, wrapping to 0 at ROWS_PER_TAG; on that wrap row_tag increments.
  - At r == IFMAP_ROWS-1, r, col_tag and row_tag reset to 0 and c increments.
- After the src word with c == IFMAP_COLS-1 and r == IFMAP_ROWS-1 is accepted, `src_ready` is forced to 0.
- When that word transfers to the GIN, the FSM goes → DONE.
- DONE: `done`=1 for one cycle; → IDLE.
- No divider: tags come from counters only. Elaboration check: ceil(IFMAP_ROWS/ROWS_PER_TAG) ≤ 2^ROW_LEN and ROWS_PER_TAG ≤ 2^ID_LEN.
- `start` while busy is ignored.

## Timing
- Reset value of every output is 0. Reset mid-sequence returns to IDLE and clears all counters. The GIN chains are not scrubbed; a fresh `start` reloads them fully.
- cfg handshake in cycle N → scan strobe high in cycle N+1.
- src handshake in cycle N → gin_enable/value/tags valid in cycle N+1.
- Sustained throughput is 1 beat/cycle when gin_ready is held high.
- Last transfer in cycle N → `done` in cycle N+1, `busy`=0 in cycle N+2.
- Simultaneous transfer and accept in one cycle: the output register is reloaded and gin_enable stays 1.
- A cfg_valid or src_valid arriving outside its phase is not accepted: cfg_ready=0 outside SCAN states, src_ready=0 outside STREAM.

## Configuration
- `GIN_SCHED_STALL_CNT_EN` defined:
  - Adds output `stall_cycles` [31:0].
  - Counts cycles with gin_enable && !gin_ready during STREAM and saturates at 2^32-1.
  - Cleared on reset and on `start`.
- Macro undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package `gin_sched_pkg`: FSM state enum and parameter-derived width constants (counter widths via $clog2).
- One sub-module, `gin_tag_counter`: r/c/row_tag/col_tag counters with advance input, tile-last output and wrap logic.
- FSM and output register live in the top module.

## Test plan
- Full sequence at defaults, cfg/src always valid, gin_ready=1:
  - 12 set_row strobes, then 168 set_id strobes, then 3 idle cycles, then 13440 beats.
  - `done` pulses once.
- Tag check: beat r=29 → row_tag=0, col_tag=29. Beat r=30 → row_tag=1, col_tag=0. Beat r=59 → row_tag=1, col_tag=29. The next beat is c+1 with tags 0/0.
- Backpressure: gin_ready held 0 for 5 cycles mid-column → value/tags constant, src_ready=0, no beat lost or duplicated. With the stall macro on, stall_cycles=5.
- cfg_valid toggling 1/0 during SCAN_ID → exactly 168 strobes total, each carrying the matching cfg_data, no strobe on idle cycles.
- rst asserted during STREAM at beat 1000, then `start` → all outputs 0 at once, then the full sequence repeats from SCAN_ROW.
- `start` pulsed during SCAN_ID → ignored; sequence length unchanged; single `done`.

Source files
------------

// File: rtl/gin_sched_pkg.sv
// gin_sched_pkg
//   Shared definitions for the GIN ifmap scheduler.
//   - sched_state_t : sequencer FSM states
//   - cnt_w()       : counter width for a counter that counts 0 .. n-1
//                     (parameter-derived widths are computed with it inside
//                     each module, because they depend on module parameters)
package gin_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN_ROW = 3'd1,
        ST_SCAN_ID  = 3'd2,
        ST_GAP      = 3'd3,
        ST_STREAM   = 3'd4,
        ST_DONE     = 3'd5
    } sched_state_t;

    // Width for a counter holding values 0 .. n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gin_tag_counter.sv
// gin_tag_counter
//   Walks a column-major ifmap tile (c outer, r inner) and produces the GIN
//   row_tag / col_tag for the current position. Tags are pure counters:
//   col_tag counts rows inside one tag group and wraps at ROWS_PER_TAG, which
//   bumps row_tag; the end of a column clears r and both tags.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clr           synchronous clear back to the first tile position
//   advance       step to the next position (one ifmap word accepted)
//   row_tag       tag for the current position
//   col_tag       tag for the current position
//   tile_last     current position is c == IFMAP_COLS-1, r == IFMAP_ROWS-1
module gin_tag_counter
    import gin_sched_pkg::*;
#(
    parameter int ROW_LEN      = 4,
    parameter int ID_LEN       = 5,
    parameter int IFMAP_ROWS   = 60,
    parameter int IFMAP_COLS   = 224,
    parameter int ROWS_PER_TAG = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               advance,
    output logic [ROW_LEN-1:0] row_tag,
    output logic [ID_LEN-1:0]  col_tag,
    output logic               tile_last
);

    localparam int R_W = cnt_w(IFMAP_ROWS);
    localparam int C_W = cnt_w(IFMAP_COLS);

    logic [R_W-1:0] r;
    logic [C_W-1:0] c;
    logic           row_end;
    logic           col_end;
    logic           tag_wrap;

    assign row_end   = (r == R_W'(IFMAP_ROWS - 1));
    assign col_end   = (c == C_W'(IFMAP_COLS - 1));
    assign tag_wrap  = (col_tag == ID_LEN'(ROWS_PER_TAG - 1));
    assign tile_last = row_end && col_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r       <= '0;
            c       <= '0;
            row_tag <= '0;
            col_tag <= '0;
        end else if (clr) begin
            r       <= '0;
            c       <= '0;
            row_tag <= '0;
            col_tag <= '0;
        end else if (advance) begin
            if (row_end) begin
                // End of column: the tag groups restart with the next column,
                // and the tile wraps so the next sequence starts at (0,0).
                r       <= '0;
                row_tag <= '0;
                col_tag <= '0;
                c       <= col_end ? '0 : c + C_W'(1);
            end else begin
                r <= r + R_W'(1);
                if (tag_wrap) begin
                    col_tag <= '0;
                    row_tag <= row_tag + ROW_LEN'(1);
                end else begin
                    col_tag <= col_tag + ID_LEN'(1);
                end
            end
        end
    end

endmodule

// File: rtl/gin_ifmap_scheduler.sv
// gin_ifmap_scheduler
//   Sequencer in front of the GIN ifmap multicast network. After start it
//   shifts the row-tag chain (XBUS_NUMS beats), then the PE-ID chain
//   (XBUS_NUMS*PE_NUMS beats), waits GAP_CYCLES, then streams one
//   column-major ifmap tile with generated row/col tags under the GIN
//   ready handshake.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   start / busy / done         sequence control and status
//   cfg_valid/cfg_data/cfg_ready  scan word source (valid/ready)
//   src_valid/src_data/src_ready  ifmap word source (valid/ready)
//   gin_set_row, gin_row_scan_in  row-tag chain scan port
//   gin_set_id,  gin_id_scan_in   PE-ID chain scan port
//   gin_enable, gin_row_tag, gin_col_tag, gin_value, gin_ready  GIN stream
//   stall_cycles                only with GIN_SCHED_STALL_CNT_EN: saturating
//                               count of stalled STREAM cycles
// Build option:
//   GIN_SCHED_STALL_CNT_EN  adds the stall_cycles counter and port.
module gin_ifmap_scheduler
    import gin_sched_pkg::*;
#(
    parameter int XBUS_NUMS    = 12,
    parameter int PE_NUMS      = 14,
    parameter int ID_LEN       = 5,
    parameter int ROW_LEN      = 4,
    parameter int VALUE_LEN    = 8,
    parameter int IFMAP_ROWS   = 60,
    parameter int IFMAP_COLS   = 224,
    parameter int ROWS_PER_TAG = 30,
    parameter int GAP_CYCLES   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    input  logic                 cfg_valid,
    input  logic [7:0]           cfg_data,
    output logic                 cfg_ready,
    input  logic                 src_valid,
    input  logic [VALUE_LEN-1:0] src_data,
    output logic                 src_ready,
    output logic                 gin_set_row,
    output logic [ROW_LEN-1:0]   gin_row_scan_in,
    output logic                 gin_set_id,
    output logic [ID_LEN-1:0]    gin_id_scan_in,
    output logic                 gin_enable,
    output logic [ROW_LEN-1:0]   gin_row_tag,
    output logic [ID_LEN-1:0]    gin_col_tag,
    output logic [VALUE_LEN-1:0] gin_value,
`ifdef GIN_SCHED_STALL_CNT_EN
    output logic [31:0]          stall_cycles,
`endif
    input  logic                 gin_ready
);

    localparam int ID_BEATS = XBUS_NUMS * PE_NUMS;
    localparam int SCAN_W   = cnt_w(ID_BEATS > XBUS_NUMS ? ID_BEATS : XBUS_NUMS);
    localparam int GAP_W    = cnt_w(GAP_CYCLES);

    // Tags come from counters only, so every tag value must fit its field.
    if ((IFMAP_ROWS + ROWS_PER_TAG - 1) / ROWS_PER_TAG > (1 << ROW_LEN)) begin : g_row_tag_chk
        $error("row_tag too narrow for IFMAP_ROWS/ROWS_PER_TAG");
    end
    if (ROWS_PER_TAG > (1 << ID_LEN)) begin : g_col_tag_chk
        $error("col_tag too narrow for ROWS_PER_TAG");
    end
    if (ROW_LEN > 8 || ID_LEN > 8) begin : g_cfg_w_chk
        $error("scan words wider than cfg_data");
    end

    sched_state_t state;
    sched_state_t state_nxt;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               last_taken;
    logic               start_take;
    logic               cfg_hs;
    logic               src_hs;
    logic               gin_xfer;
    logic               tile_last;
    logic [ROW_LEN-1:0] cur_row_tag;
    logic [ID_LEN-1:0]  cur_col_tag;
    logic               cfg_unused;

    // Scan-port and stream output registers
    logic                 set_row_p1;
    logic [ROW_LEN-1:0]   row_scan_p1;
    logic                 set_id_p1;
    logic [ID_LEN-1:0]    id_scan_p1;
    logic                 vld_p1;
    logic [ROW_LEN-1:0]   row_tag_p1;
    logic [ID_LEN-1:0]    col_tag_p1;
    logic [VALUE_LEN-1:0] value_p1;

    // Upper cfg_data bits are don't-care in both scan phases.
    assign cfg_unused = ^cfg_data;

    assign start_take = (state == ST_IDLE) && start;
    assign cfg_ready  = (state == ST_SCAN_ROW) || (state == ST_SCAN_ID);
    assign cfg_hs     = cfg_valid && cfg_ready;
    // Once the tile's last word is held, no further word may enter; the
    // register only drains.
    assign src_ready  = (state == ST_STREAM) && !last_taken && (!vld_p1 || gin_ready);
    assign src_hs     = src_valid && src_ready;
    assign gin_xfer   = vld_p1 && gin_ready;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);

    gin_tag_counter #(
        .ROW_LEN      (ROW_LEN),
        .ID_LEN       (ID_LEN),
        .IFMAP_ROWS   (IFMAP_ROWS),
        .IFMAP_COLS   (IFMAP_COLS),
        .ROWS_PER_TAG (ROWS_PER_TAG)
    ) u_tag_counter (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_take),
        .advance   (src_hs),
        .row_tag   (cur_row_tag),
        .col_tag   (cur_col_tag),
        .tile_last (tile_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start) state_nxt = ST_SCAN_ROW;
            ST_SCAN_ROW: if (cfg_hs && scan_cnt == SCAN_W'(XBUS_NUMS - 1)) state_nxt = ST_SCAN_ID;
            ST_SCAN_ID:  if (cfg_hs && scan_cnt == SCAN_W'(ID_BEATS - 1)) state_nxt = ST_GAP;
            ST_GAP:      if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) state_nxt = ST_STREAM;
            ST_STREAM:   if (last_taken && gin_xfer) state_nxt = ST_DONE;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Phase counters; scan_cnt restarts whenever the FSM changes phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt   <= '0;
            gap_cnt    <= '0;
            last_taken <= 1'b0;
        end else begin
            if (state_nxt != state) begin
                scan_cnt <= '0;
            end else if (cfg_hs) begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end

            if (state == ST_GAP) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end else begin
                gap_cnt <= '0;
            end

            if (state == ST_IDLE) begin
                last_taken <= 1'b0;
            end else if (src_hs && tile_last) begin
                last_taken <= 1'b1;
            end
        end
    end

    // ---- stage p1: scan strobes, one cycle per accepted cfg word ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_row_p1  <= 1'b0;
            row_scan_p1 <= '0;
            set_id_p1   <= 1'b0;
            id_scan_p1  <= '0;
        end else begin
            set_row_p1 <= cfg_hs && (state == ST_SCAN_ROW);
            set_id_p1  <= cfg_hs && (state == ST_SCAN_ID);
            if (cfg_hs && state == ST_SCAN_ROW) begin
                row_scan_p1 <= cfg_data[ROW_LEN-1:0];
            end
            if (cfg_hs && state == ST_SCAN_ID) begin
                id_scan_p1 <= cfg_data[ID_LEN-1:0];
            end
        end
    end

    // ---- stage p1: single-entry stream register toward the GIN ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1     <= 1'b0;
            row_tag_p1 <= '0;
            col_tag_p1 <= '0;
            value_p1   <= '0;
        end else if (src_hs) begin
            // Covers the simultaneous drain+refill case as well.
            vld_p1     <= 1'b1;
            row_tag_p1 <= cur_row_tag;
            col_tag_p1 <= cur_col_tag;
            value_p1   <= src_data;
        end else if (gin_xfer) begin
            vld_p1 <= 1'b0;
        end
    end

    assign gin_set_row     = set_row_p1;
    assign gin_row_scan_in = row_scan_p1;
    assign gin_set_id      = set_id_p1;
    assign gin_id_scan_in  = id_scan_p1;
    assign gin_enable      = vld_p1;
    assign gin_row_tag     = row_tag_p1;
    assign gin_col_tag     = col_tag_p1;
    assign gin_value       = value_p1;

`ifdef GIN_SCHED_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (start_take) begin
            stall_cycles <= '0;
        end else if (state == ST_STREAM && vld_p1 && !gin_ready && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gin_ifmap_scheduler.sv
module tb_gin_ifmap_scheduler;

    localparam int XB    = 12;
    localparam int PE    = 14;
    localparam int IDB   = XB * PE;
    localparam int ROWS  = 60;
    localparam int COLS  = 224;
    localparam int RPT   = 30;
    localparam int BEATS = ROWS * COLS;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       cfg_valid;
    logic [7:0] cfg_data;
    logic       cfg_ready;
    logic       src_valid;
    logic [7:0] src_data;
    logic       src_ready;
    logic       gin_set_row;
    logic [3:0] gin_row_scan_in;
    logic       gin_set_id;
    logic [4:0] gin_id_scan_in;
    logic       gin_enable;
    logic [3:0] gin_row_tag;
    logic [4:0] gin_col_tag;
    logic [7:0] gin_value;
    logic       gin_ready;
`ifdef GIN_SCHED_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    gin_ifmap_scheduler #(
        .XBUS_NUMS(XB), .PE_NUMS(PE), .ID_LEN(5), .ROW_LEN(4), .VALUE_LEN(8),
        .IFMAP_ROWS(ROWS), .IFMAP_COLS(COLS), .ROWS_PER_TAG(RPT), .GAP_CYCLES(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .gin_set_row(gin_set_row), .gin_row_scan_in(gin_row_scan_in),
        .gin_set_id(gin_set_id), .gin_id_scan_in(gin_id_scan_in),
        .gin_enable(gin_enable), .gin_row_tag(gin_row_tag), .gin_col_tag(gin_col_tag),
        .gin_value(gin_value),
`ifdef GIN_SCHED_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .gin_ready(gin_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Bench model state
    int cyc = 0;
    int n_cfg, n_src, n_xfer, n_row, n_id, n_done, n_stall, n_tag_hits;
    int last_id_cyc, first_en_cyc, last_xfer_cyc;
    bit toggle_en, ign_en, ign_done, manual, start_req, stall_armed;
    int stall_left;

    typedef struct {
        int beat;
        int row;
        int col;
    } tag_vec_t;
    tag_vec_t tag_tbl[6];

    typedef struct {
        logic       st;
        logic       cv;
        logic [7:0] cd;
        logic       sv;
        logic       e_busy;
        logic       e_cr;
        logic       e_sr;
        logic       e_set;
        logic [3:0] e_scan;
    } vec_t;
    vec_t vecs[6];

    task automatic clear_model();
        n_cfg = 0; n_src = 0; n_xfer = 0; n_row = 0; n_id = 0; n_done = 0;
        n_stall = 0; n_tag_hits = 0;
        last_id_cyc = -1; first_en_cyc = -1; last_xfer_cyc = -1;
        ign_done = 0; stall_left = 0;
    endtask

    task automatic drive();
        if (manual) return;
        start = start_req;
        start_req = 0;
        if (ign_en && !ign_done && n_cfg == 50) begin
            start = 1'b1;
            ign_done = 1;
        end
        cfg_valid = (toggle_en && n_cfg >= XB) ? cyc[0] : 1'b1;
        cfg_data  = cfg_valid ? {3'b111, n_cfg[4:0]} : 8'h55;
        src_valid = 1'b1;
        src_data  = n_src[7:0];
        if (stall_armed && n_xfer == 100) begin
            stall_left = 5;
            stall_armed = 0;
        end
        if (stall_left > 0) begin
            gin_ready = 1'b0;
            stall_left--;
        end else begin
            gin_ready = 1'b1;
        end
    endtask

    task automatic tick();
        bit pc, ps, px;
        int idx, b, r;
        idx = -1;
        pc = cfg_valid && cfg_ready;
        ps = src_valid && src_ready;
        px = gin_enable && gin_ready;
        chk("cfg_ready_phase", int'(cfg_ready && (n_cfg >= XB + IDB || n_src > 0)), 0);
        chk("src_ready_phase", int'(src_ready && (n_id < IDB || n_src >= BEATS)), 0);
        if (gin_enable) begin
            b = n_xfer;
            r = b % ROWS;
            chk("beat_value", int'(gin_value), b % 256);
            chk("beat_row_tag", int'(gin_row_tag), r / RPT);
            chk("beat_col_tag", int'(gin_col_tag), r % RPT);
            if (first_en_cyc < 0) first_en_cyc = cyc;
            if (!gin_ready) begin
                n_stall++;
                chk("stall_src_ready", int'(src_ready), 0);
            end
            if (px) begin
                for (int i = 0; i < 6; i++) begin
                    if (tag_tbl[i].beat == b) begin
                        n_tag_hits++;
                        chk("tbl_row_tag", int'(gin_row_tag), tag_tbl[i].row);
                        chk("tbl_col_tag", int'(gin_col_tag), tag_tbl[i].col);
                    end
                end
                if (b == BEATS - 1) last_xfer_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pc) begin
            idx = n_cfg;
            n_cfg++;
        end
        chk("set_row", int'(gin_set_row), int'(pc && idx < XB));
        if (gin_set_row) begin
            n_row++;
            chk("row_scan_data", int'(gin_row_scan_in), idx % 16);
        end
        chk("set_id", int'(gin_set_id), int'(pc && idx >= XB));
        if (gin_set_id) begin
            n_id++;
            last_id_cyc = cyc;
            chk("id_scan_data", int'(gin_id_scan_in), idx % 32);
        end
        if (ps) n_src++;
        if (px) n_xfer++;
        if (done) begin
            n_done++;
            chk("done_timing", cyc, last_xfer_cyc + 1);
            chk("busy_in_done", int'(busy), 1);
        end
        if (last_xfer_cyc >= 0 && cyc == last_xfer_cyc + 2) chk("busy_after_done", int'(busy), 0);
        drive();
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_cfg_ready"}, int'(cfg_ready), 0);
        chk({tag, "_src_ready"}, int'(src_ready), 0);
        chk({tag, "_set_row"}, int'(gin_set_row), 0);
        chk({tag, "_row_scan"}, int'(gin_row_scan_in), 0);
        chk({tag, "_set_id"}, int'(gin_set_id), 0);
        chk({tag, "_id_scan"}, int'(gin_id_scan_in), 0);
        chk({tag, "_enable"}, int'(gin_enable), 0);
        chk({tag, "_row_tag"}, int'(gin_row_tag), 0);
        chk({tag, "_col_tag"}, int'(gin_col_tag), 0);
        chk({tag, "_value"}, int'(gin_value), 0);
`ifdef GIN_SCHED_STALL_CNT_EN
        chk({tag, "_stall_cycles"}, int'(stall_cycles), 0);
`endif
    endtask

    task automatic run_to_done(input string tag, input int budget);
        int limit;
        limit = cyc + budget;
        while (n_done == 0 && cyc < limit) tick();
        chk({tag, "_reached_done"}, int'(n_done > 0), 1);
        repeat (3) tick();
        chk({tag, "_row_strobes"}, n_row, XB);
        chk({tag, "_id_strobes"}, n_id, IDB);
        chk({tag, "_beats"}, n_xfer, BEATS);
        chk({tag, "_done_pulses"}, n_done, 1);
        chk({tag, "_gap_cycles"}, first_en_cyc - last_id_cyc - 1, 3);
        chk({tag, "_tag_table_hits"}, n_tag_hits, 6);
    endtask

    initial begin
        tag_tbl[0] = '{29, 0, 29};
        tag_tbl[1] = '{30, 1, 0};
        tag_tbl[2] = '{59, 1, 29};
        tag_tbl[3] = '{60, 0, 0};
        tag_tbl[4] = '{90, 1, 0};
        tag_tbl[5] = '{BEATS - 1, 1, 29};
        //            st    cv    cd     sv    busy  cr    sr    set   scan
        vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
        vecs[1] = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
        vecs[2] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
        vecs[3] = '{1'b0, 1'b1, 8'hA0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0};
        vecs[4] = '{1'b0, 1'b0, 8'h5F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0};
        vecs[5] = '{1'b0, 1'b1, 8'hE1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'h1};

        rst = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
        src_valid = 1'b0; src_data = 8'h00; gin_ready = 1'b1;
        manual = 1; toggle_en = 0; ign_en = 0; start_req = 0; stall_armed = 0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;

        // Out-of-phase inputs in IDLE, start, and the first row-scan beats.
        for (int i = 0; i < 6; i++) begin
            start = vecs[i].st; cfg_valid = vecs[i].cv; cfg_data = vecs[i].cd;
            src_valid = vecs[i].sv; src_data = 8'h00;
            #1;
            tick();
            chk("vec_busy", int'(busy), int'(vecs[i].e_busy));
            chk("vec_cfg_ready", int'(cfg_ready), int'(vecs[i].e_cr));
            chk("vec_src_ready", int'(src_ready), int'(vecs[i].e_sr));
            chk("vec_set_row", int'(gin_set_row), int'(vecs[i].e_set));
            chk("vec_enable", int'(gin_enable), 0);
            if (vecs[i].e_set) chk("vec_row_scan", int'(gin_row_scan_in), int'(vecs[i].e_scan));
        end

        // Run A: toggling cfg_valid in the ID phase, ignored start, backpressure.
        manual = 0; toggle_en = 1; ign_en = 1; stall_armed = 1;
        drive();
        #1;
        run_to_done("runA", 20000);
        chk("runA_stall_obs", n_stall, 5);
`ifdef GIN_SCHED_STALL_CNT_EN
        chk("runA_stall_cycles", int'(stall_cycles), 5);
`endif

        // Run B: reset during STREAM at beat 1000, then a clean full sequence.
        clear_model();
        toggle_en = 0; ign_en = 0; stall_armed = 0; start_req = 1;
        drive();
        #1;
        begin
            int limit;
            limit = cyc + 5000;
            while (n_xfer < 1000 && cyc < limit) tick();
            chk("runB_reached_beat1000", int'(n_xfer >= 1000), 1);
        end
        rst = 1'b0;
        #1;
        check_zero("mid_reset");
        manual = 1;
        start = 1'b0; cfg_valid = 1'b0; src_valid = 1'b0; gin_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        clear_model();
        manual = 0; start_req = 1;
        drive();
        #1;
        run_to_done("runB", 20000);
        chk("runB_throughput", last_xfer_cyc - first_en_cyc, BEATS - 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
